// File: rtl/aes_pkg.sv
// Shared constants and types for the AES key-expansion memory: round counts,
// key-length encodings, controller states and the round-constant helpers.
package aes_pkg;

  localparam logic [3:0] AES128_NUM_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_NUM_ROUNDS = 4'he;
  localparam logic [7:0] RCON_INIT         = 8'h8d;

  typedef enum logic {
    KEYLEN_128 = 1'b0,
    KEYLEN_256 = 1'b1
  } keylen_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT     = 2'd1,
    GENERATE = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Multiply by x in GF(2^8); 8'h8d wraps to 8'h01 on the first step.
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_mem.sv
// AES round-key generator and store; SubWord comes from an external shared S-box.
// Define AES_KEY_MEM_256_EN to add AES-256 support and a 15-entry memory.
module aes_key_mem
  import aes_pkg::*;
#(
  parameter logic [3:0] AES128_ROUNDS = AES128_NUM_ROUNDS,
  parameter logic [3:0] AES256_ROUNDS = AES256_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

`ifdef AES_KEY_MEM_256_EN
  localparam int MEM_DEPTH = 15;
`else
  localparam int MEM_DEPTH = 11;
`endif

  state_e       state_q;
  logic         ready_q;
  logic [3:0]   round_ctr_q;
  logic [7:0]   rcon_q;
  logic [7:0]   rcon_d;
  logic [127:0] key_hi_q;
  logic [127:0] key_lo;
  logic [127:0] prev_key0_q;
  logic [127:0] prev_key1_q;
  logic [127:0] key_mem_q [MEM_DEPTH];
  logic         is_256;
  logic         uses_rcon;
  logic [3:0]   num_rounds;
  logic [31:0]  temp;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] base;
  logic [127:0] new_key;
  logic         start;

  assign start = (state_q == IDLE) && init;

`ifdef AES_KEY_MEM_256_EN
  keylen_e      keylen_q;
  logic [127:0] key_lo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keylen_q <= KEYLEN_128;
      key_lo_q <= '0;
    end else if (start) begin
      keylen_q <= keylen_e'(keylen);
      key_lo_q <= key[127:0];
    end
  end

  assign is_256 = (keylen_q == KEYLEN_256);
  assign key_lo = key_lo_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{keylen, key[127:0]};
  assign is_256        = 1'b0;
  assign key_lo        = '0;
`endif

  // The key is captured only when an expansion starts, so later changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_hi_q <= '0;
    else if (start) key_hi_q <= key[255:128];
  end

  assign num_rounds = is_256 ? AES256_ROUNDS : AES128_ROUNDS;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rcon_d    = gm2(rcon_q);
    base      = prev_key1_q;
    temp      = rot_word(new_sboxw) ^ {rcon_d, 24'h0};
    uses_rcon = (round_ctr_q != 4'd0);
    if (is_256) begin
      base = prev_key0_q;
      if (round_ctr_q[0]) begin
        temp      = new_sboxw;
        uses_rcon = 1'b0;
      end
      if (round_ctr_q < 4'd2) uses_rcon = 1'b0;
    end
    w0 = base[127:96] ^ temp;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    new_key = {w0, w1, w2, w3};
    if (round_ctr_q == 4'd0) new_key = key_hi_q;
    else if (is_256 && (round_ctr_q == 4'd1)) new_key = key_lo;
  end

  // NOTE: the key memory is reset in full so an aborted expansion leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      round_ctr_q <= '0;
      rcon_q      <= RCON_INIT;
      prev_key0_q <= '0;
      prev_key1_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) key_mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (init) begin
            ready_q     <= 1'b0;
            round_ctr_q <= '0;
            rcon_q      <= RCON_INIT;
            state_q     <= INIT;
          end
        end
        INIT: state_q <= GENERATE;
        GENERATE: begin
          key_mem_q[round_ctr_q] <= new_key;
          prev_key0_q            <= prev_key1_q;
          prev_key1_q            <= new_key;
          round_ctr_q            <= round_ctr_q + 4'd1;
          if (uses_rcon) rcon_q <= rcon_d;
          if (round_ctr_q == num_rounds) begin
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign sboxw     = (state_q == GENERATE) ? prev_key1_q[31:0] : 32'h0;
  assign round_key = (int'(round) < MEM_DEPTH) ? key_mem_q[round] : 128'h0;

endmodule

// File: tb/tb_aes_key_mem.sv
// Self-checking bench for aes_key_mem with a behavioural S-box and a queue of
// expected round-key reads; AES-256 cases run when AES_KEY_MEM_256_EN is defined.
module tb_aes_key_mem;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] key = '0;
  logic         keylen = 1'b0;
  logic         init = 1'b0;
  logic [3:0]   round = '0;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K3_LO  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K3_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  assign new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                      sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};

  aes_key_mem dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .keylen    (keylen),
    .init      (init),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [3:0]   rnd;
    logic [127:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_key(input string tag, input logic [3:0] r, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.rnd = r;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      round = e.rnd;
      #1;
      check(e.tag, round_key, e.val);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    for (int r = 0; r < 16; r++) expect_key($sformatf("%s_r%0d", tag, r), 4'(r), '0);
  endtask

  // Leaves time one step after the edge E0 at which init is sampled.
  task automatic start(input logic [255:0] k, input logic kl);
    repeat (2) @(negedge clk);
    key    = k;
    keylen = kl;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    check("ready_clear", 128'(ready), 128'h0);
  endtask

  task automatic wait_ready(input string tag, input int exp_lat, input bit disturb,
                            input bit chk_sbox, input logic [31:0] sbox_exp);
    int lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 3 && chk_sbox) check({tag, "_sboxw"}, 128'(sboxw), 128'(sbox_exp));
      if (disturb) begin
        if (n == 3) begin
          key    = ~key;
          keylen = ~keylen;
        end
        if (n == 4) init = 1'b1;
        if (n == 5) init = 1'b0;
      end
      if (ready) lat = n;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(ready), 128'h1);
    check("rst_sboxw", 128'(sboxw), 128'h0);
    expect_all_zero("rst");
    drain();
    @(negedge clk);
    reset_n = 1'b1;

    start({K1, 128'h0}, 1'b0);
    wait_ready("k1", 12, 1'b0, 1'b1, 32'h2a6c7605);
    expect_key("k1_r0", 4'd0, K1);
    expect_key("k1_r1", 4'd1, K1_R1);
    expect_key("k1_r10", 4'd10, K1_R10);
    expect_key("k1_r15", 4'd15, '0);
    drain();
    check("idle_sboxw", 128'(sboxw), 128'h0);

    start({K2, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff}, 1'b0);
    wait_ready("k2", 12, 1'b0, 1'b0, 32'h0);
    expect_key("k2_r0", 4'd0, K2);
    expect_key("k2_r10", 4'd10, K2_R10);
    drain();

`ifdef AES_KEY_MEM_256_EN
    start({K2, K3_LO}, 1'b1);
    wait_ready("k3", 16, 1'b0, 1'b0, 32'h0);
    expect_key("k3_r0", 4'd0, K2);
    expect_key("k3_r1", 4'd1, K3_LO);
    expect_key("k3_r14", 4'd14, K3_R14);
    expect_key("k3_r15", 4'd15, '0);
    drain();

    start({K1, 128'h0}, 1'b0);
    wait_ready("k1b", 12, 1'b0, 1'b0, 32'h0);
    expect_key("k1b_r10", 4'd10, K1_R10);
    expect_key("retain_r14", 4'd14, K3_R14);
    drain();
`else
    start({K1, 128'($urandom) << 64 | 128'($urandom)}, 1'b1);
    wait_ready("k1_len1", 12, 1'b0, 1'b0, 32'h0);
    expect_key("len1_r1", 4'd1, K1_R1);
    expect_key("len1_r10", 4'd10, K1_R10);
    for (int r = 11; r < 16; r++) expect_key($sformatf("len1_r%0d", r), 4'(r), '0);
    drain();
`endif

    start({K1, 128'h0}, 1'b0);
    wait_ready("k1_reinit", 12, 1'b1, 1'b0, 32'h0);
    keylen = 1'b0;
    expect_key("reinit_r1", 4'd1, K1_R1);
    expect_key("reinit_r10", 4'd10, K1_R10);
    drain();

    start({K1, 128'h0}, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 128'(ready), 128'h1);
    check("abort_sboxw", 128'(sboxw), 128'h0);
    expect_all_zero("abort");
    drain();
    @(negedge clk);
    reset_n = 1'b1;

    start({K1, 128'h0}, 1'b0);
    wait_ready("k1_fresh", 12, 1'b0, 1'b0, 32'h0);
    expect_key("fresh_r1", 4'd1, K1_R1);
    expect_key("fresh_r10", 4'd10, K1_R10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
